risc_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the RISC core, sitting between instruction memory and decode.
- Generates the PC and issues fetch requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, tagged with their PC, in a small prefetch queue, and presents them to decode through a valid/ready handshake.
- Supports decode back-pressure, branch/jump redirect with flush, and modulo-2^AW PC wrap-around.

---
 rtl/risc_fetch_pkg.sv | 13 +
 rtl/risc_fetch_queue.sv | 53 +++++
 rtl/risc_fetch_unit.sv | 90 +++++++++
 tb/tb_risc_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_fetch_pkg.sv
// rtl/risc_fetch_pkg.sv - shared constants and queue entry type for the fetch stage
package risc_fetch_pkg;

  localparam int DEF_IW = 13;
  localparam int DEF_AW = 5;
  localparam logic [DEF_IW-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [DEF_AW-1:0] pc;
    logic [DEF_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/risc_fetch_queue.sv
// rtl/risc_fetch_queue.sv - DEPTH-entry circular prefetch FIFO with clear over push
module risc_fetch_queue
  import risc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/risc_fetch_unit.sv
// rtl/risc_fetch_unit.sv - PC generation, fetch issue and redirect handling in front of decode
module risc_fetch_unit
  import risc_fetch_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int AW = DEF_AW,
  parameter int DEPTH = 2,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [IW-1:0] NOP = IW'(NOP_INSTR)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  logic [AW-1:0] fetch_pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          pop;
  logic          push;
  logic [OW-1:0] occ;
  entry_t        head;
  entry_t        push_entry;

  assign ir_valid = !q_empty;
  assign pop      = ir_valid & ir_ready;
  assign push     = inflight & ~redirect;

  // Reserve a slot for the outstanding response so a push never meets a full queue.
  assign occ       = {1'b0, q_count} + OW'(inflight) - OW'(pop);
  assign imem_req  = rst_n & ~redirect & (occ < OW'(DEPTH));
  assign imem_addr = fetch_pc;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (imem_req) begin
      fetch_pc    <= fetch_pc + AW'(1);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  risc_fetch_queue #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (q_count),
    .empty    (q_empty)
  );

  assign ir = ir_valid ? head.instr : NOP;
  assign pc = ir_valid ? head.pc : '0;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb/tb_risc_fetch_unit.sv - bench for risc_fetch_unit at DEPTH=2/IW=13 and DEPTH=4/IW=16
module tb_risc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       redirect = 1'b0;
  logic [4:0] redirect_pc = '0;
  logic       ir_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int D = (g == 0) ? 2 : 4;
    localparam int W = (g == 0) ? 13 : 16;

    logic         imem_req;
    logic [4:0]   imem_addr;
    logic [W-1:0] imem_data = '0;
    logic         ir_valid;
    logic [W-1:0] ir;
    logic [4:0]   pc;

    risc_fetch_unit #(.IW(W), .AW(5), .DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .ir         (ir),
      .pc         (pc)
    );

    // Instruction memory: word at address a holds 0x100 + a, one-cycle read.
    always @(posedge clk) begin
      if (imem_req) imem_data <= W'(32'h100 + 32'(imem_addr));
    end

    // Reference: queue of delivered-to-be PCs plus one outstanding request.
    int mq[$];
    bit mpend = 1'b0;
    int mpend_pc = 0;
    int mfpc = 0;
    int mhead = -1;
    bit m_r;
    bit m_p;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mq.delete();
        mpend = 1'b0;
        mfpc = 0;
      end else begin
        m_p = (mq.size() != 0) && ir_ready;
        m_r = !redirect && ((mq.size() + int'(mpend) - int'(m_p)) < D);
        if (redirect) begin
          mq.delete();
          mpend = 1'b0;
          mfpc = int'(redirect_pc);
        end else begin
          if (m_p) void'(mq.pop_front());
          if (mpend) mq.push_back(mpend_pc);
          mpend = m_r;
          if (m_r) begin
            mpend_pc = mfpc;
            mfpc = (mfpc + 1) % 32;
          end
        end
      end
      mhead = (mq.size() != 0) ? mq[0] : -1;
    end

    int e_req;
    always @(negedge clk) begin
      e_req = int'(rst_n && !redirect &&
                   ((mq.size() + int'(mpend) - int'((mq.size() != 0) && ir_ready)) < D));
      chk("imem_req", g, int'(imem_req), e_req);
      if (e_req != 0) chk("imem_addr", g, int'(imem_addr), mfpc);
      chk("ir_valid", g, int'(ir_valid), int'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("pc", g, int'(pc), mq[0]);
        chk("ir", g, int'(ir), 256 + mq[0]);
      end else begin
        chk("pc_empty", g, int'(pc), 0);
        chk("ir_nop", g, int'(ir), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int held;
  bit found;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 0, int'(cfg[0].ir_valid), 0);
    chk("rst_req", 0, int'(cfg[0].imem_req), 0);
    chk("rst_pc", 0, int'(cfg[0].pc), 0);
    chk("rst_ir", 0, int'(cfg[0].ir), 0);

    // Release: cycle 0
    step();
    rst_n = 1'b1;
    ir_ready = 1'b1;
    @(negedge clk);
    chk("c0_req", 0, int'(cfg[0].imem_req), 1);
    chk("c0_addr", 0, int'(cfg[0].imem_addr), 0);
    step();
    @(negedge clk);
    chk("c1_addr", 0, int'(cfg[0].imem_addr), 1);
    chk("c1_valid", 0, int'(cfg[0].ir_valid), 0);
    step();
    @(negedge clk);
    chk("c2_valid", 0, int'(cfg[0].ir_valid), 1);
    chk("c2_pc", 0, int'(cfg[0].pc), 0);
    chk("c2_ir", 0, int'(cfg[0].ir), 32'h100);
    for (int c = 3; c <= 40; c++) begin
      step();
      @(negedge clk);
      if (c == 33) chk("wrap_pc31", 0, int'(cfg[0].pc), 31);
      if (c == 34) chk("wrap_pc0", 0, int'(cfg[0].pc), 0);
      if (c == 35) chk("wrap_pc1", 0, int'(cfg[0].pc), 1);
    end

    // Stall for six cycles
    step();
    ir_ready = 1'b0;
    held = cfg[0].mhead;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_pc", 0, int'(cfg[0].pc), held);
      if (i == 5) chk("stall_req", 0, int'(cfg[0].imem_req), 0);
      step();
    end
    ir_ready = 1'b1;
    repeat (4) step();

    // Redirect to 0x14 while decode is stalled
    ir_ready = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 5'h14;
    step();
    redirect = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    chk("rd_valid0", 0, int'(cfg[0].ir_valid), 0);
    chk("rd_req", 0, int'(cfg[0].imem_req), 1);
    chk("rd_addr", 0, int'(cfg[0].imem_addr), 32'h14);
    step();
    step();
    @(negedge clk);
    chk("rd_pc", 0, int'(cfg[0].pc), 32'h14);
    chk("rd_ir", 0, int'(cfg[0].ir), 32'h114);

    // Redirect coinciding with the transfer of pc=7, then a second redirect
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (cfg[0].mhead == 7) found = 1'b1;
      else step();
    end
    chk("wait_pc7", 0, int'(found), 1);
    redirect = 1'b1;
    redirect_pc = 5'h1a;
    @(negedge clk);
    chk("xfer_valid", 0, int'(cfg[0].ir_valid), 1);
    chk("xfer_pc7", 0, int'(cfg[0].pc), 7);
    step();
    redirect_pc = 5'h03;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("rr_addr", 0, int'(cfg[0].imem_addr), 3);
    step();
    @(negedge clk);
    chk("rr_valid0", 0, int'(cfg[0].ir_valid), 0);
    step();
    @(negedge clk);
    chk("rr_valid1", 0, int'(cfg[0].ir_valid), 1);
    chk("rr_pc3", 0, int'(cfg[0].pc), 3);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step();
      rst_n = ($urandom % 100) != 0;
      ir_ready = ($urandom % 10) < 7;
      redirect = ($urandom % 12) == 0;
      redirect_pc = 5'($urandom % 32);
    end
    step();
    rst_n = 1'b1;
    redirect = 1'b0;
    ir_ready = 1'b1;
    repeat (8) step();

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("arst_req", g, int'(g == 0 ? cfg[0].imem_req : cfg[1].imem_req), 0);
      chk("arst_valid", g, int'(g == 0 ? cfg[0].ir_valid : cfg[1].ir_valid), 0);
      chk("arst_pc", g, int'(g == 0 ? cfg[0].pc : cfg[1].pc), 0);
      chk("arst_ir", g, int'(g == 0 ? 32'(cfg[0].ir) : 32'(cfg[1].ir)), 0);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_addr", 1, int'(cfg[1].imem_addr), 0);
    step();
    step();
    @(negedge clk);
    chk("rel_pc", 1, int'(cfg[1].pc), 0);
    chk("rel_ir", 1, int'(cfg[1].ir), 32'h100);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
